// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester serial link (receiver and transmitter).
package manchester_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        BLANK,
        WINDOW,
        ERRWAIT
    } rx_state_t;

    // First byte of every frame; consumed by the receiver, never delivered
    localparam logic [7:0] PREAMBLE_DEFAULT = 8'h55;

    // System clocks per sample tick; never below 1 so a tick always exists
    function automatic int unsigned tick_div(input int unsigned clkfreq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned d;
        d = clkfreq / (baud * oversample);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/manchester_tick_gen.sv
// Sample-tick generator: one-clk pulse every CLKFREQ/(BAUD*OVERSAMPLE) clks.
module manchester_tick_gen
    import manchester_pkg::*;
#(
    parameter int unsigned CLKFREQ    = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV = tick_div(CLKFREQ, BAUD, OVERSAMPLE);
    localparam int          CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt;

    // Free-running divider; tick is registered so it is glitch-free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == CW'(DIV - 1)) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + CW'(1);
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/manchester_receiver.sv
// Manchester receiver: synchronizes rxd, locks to mid-bit transitions,
// checks the preamble byte, and delivers payload bytes LSB first.
// A '1' is low-then-high, a '0' is high-then-low; the line idles high.
// Outputs valid, eof and err are mutually exclusive one-clk pulses.
module manchester_receiver
    import manchester_pkg::*;
#(
    parameter int unsigned CLKFREQ    = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter logic [7:0]  PREAMBLE   = PREAMBLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       eof,
    output logic       err
);

    localparam int unsigned N  = OVERSAMPLE;
    localparam int          CW = $clog2(2 * N + 1);

    // Tick-count thresholds, all measured from the last accepted edge
    localparam logic [CW-1:0] Q1  = CW'(N / 4);      // earliest valid first mid-bit
    localparam logic [CW-1:0] Q3  = CW'(3 * N / 4);  // end of blanking interval
    localparam logic [CW-1:0] T15 = CW'(3 * N / 2);  // missing mid-bit timeout
    localparam logic [CW-1:0] T2  = CW'(2 * N);      // idle-high needed to recover

    logic            tick;
    logic            sync1, sync2, line_prev;
    logic            rise, fall;
    logic [7:0]      byte_nxt;

    rx_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic            pre_ok;

    manchester_tick_gen #(
        .CLKFREQ   (CLKFREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= rxd;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    assign rise     = sync2 & ~line_prev;
    assign fall     = ~sync2 & line_prev;
    // Bit value is the new line level; assemble LSB first from the MSB side
    assign byte_nxt = {sync2, shreg[7:1]};

    // Receive FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            pre_ok <= 1'b0;
            data   <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            eof    <= 1'b0;
            err    <= 1'b0;
        end else begin
            valid <= 1'b0;
            eof   <= 1'b0;
            err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (fall) begin
                        state  <= SYNC;
                        busy   <= 1'b1;
                        bitcnt <= '0;
                        shreg  <= '0;
                        pre_ok <= 1'b0;
                    end
                end

                SYNC: begin
                    if (rise) begin
                        if (cnt < Q1) begin
                            // Too short to be a real half-bit: treat as glitch
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            shreg  <= {1'b1, shreg[7:1]};
                            bitcnt <= 3'd1;
                            cnt    <= '0;
                            state  <= BLANK;
                        end
                    end else if (tick && cnt == Q3) begin
                        cnt   <= '0;
                        state <= ERRWAIT;
                    end else if (tick) begin
                        cnt <= cnt + CW'(1);
                    end
                end

                BLANK: begin
                    // Bit-boundary transitions land here and are ignored
                    if (cnt >= Q3) begin
                        state <= WINDOW;
                    end
                    if (tick) begin
                        cnt <= cnt + CW'(1);
                    end
                end

                WINDOW: begin
                    if (rise || fall) begin
                        shreg  <= byte_nxt;
                        bitcnt <= bitcnt + 3'd1;
                        cnt    <= '0;
                        state  <= BLANK;
                        if (bitcnt == 3'd7) begin
                            if (!pre_ok) begin
                                if (byte_nxt != PREAMBLE) begin
                                    err   <= 1'b1;
                                    state <= ERRWAIT;
                                end else begin
                                    pre_ok <= 1'b1;
                                end
                            end else begin
                                data  <= byte_nxt;
                                valid <= 1'b1;
                            end
                        end
                    end else if (cnt >= T15) begin
                        cnt <= '0;
                        if (sync2 && bitcnt == 3'd0 && pre_ok) begin
                            eof   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            err   <= 1'b1;
                            state <= ERRWAIT;
                        end
                    end else if (tick) begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ERRWAIT: begin
                    // Recover only after an unbroken idle-high stretch
                    if (!sync2) begin
                        cnt <= '0;
                    end else if (cnt >= T2) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tick) begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_manchester_receiver.sv
// Directed bench for manchester_receiver with a queue-based scoreboard.
// Tick divisor is 4 clks and a bit is 64 clks, keeping the run short.
module tb_manchester_receiver;

    localparam int unsigned CLKFREQ    = 1_000_000;
    localparam int unsigned BAUD       = 15_625;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int          BIT        = 64;

    localparam logic [1:0] EV_VALID = 2'd1;
    localparam logic [1:0] EV_EOF   = 2'd2;
    localparam logic [1:0] EV_ERR   = 2'd3;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       eof;
    logic       err;

    logic [9:0] exp_q[$];
    int         n_cmp;
    int         n_bad;
    int         cyc;
    int         err_cyc;
    int         low_cyc;

    manchester_receiver #(
        .CLKFREQ   (CLKFREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE),
        .PREAMBLE  (8'h55)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .data (data),
        .valid(valid),
        .busy (busy),
        .eof  (eof),
        .err  (err)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [7:0] val);
        exp_q.push_back({kind, val});
    endtask

    // Driver tasks: rxd changes on the falling edge only
    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int p);
        rxd = ~b;
        repeat (p / 2) @(negedge clk);
        rxd = b;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit jitter);
        int jt[5];
        jt = '{64, 61, 67, 62, 66};
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i], jitter ? jt[i % 5] : BIT);
        end
    endtask

    // Monitor: pops the expected queue whenever the DUT pulses an output
    initial begin
        logic [9:0] got;
        logic [9:0] want;
        err_cyc = 0;
        forever begin
            @(negedge clk);
            if (valid || eof || err) begin
                check("pulse_exclusive", 32'($countones({valid, eof, err})), 32'd1);
                if (eof) check("busy_low_on_eof", 32'(busy), 32'd0);
                if (err) err_cyc = cyc;
                if (valid)    got = {EV_VALID, data};
                else if (eof) got = {EV_EOF, 8'h00};
                else          got = {EV_ERR, 8'h00};
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got 0x%0h with empty queue (cycle %0d)", got, cyc);
                end else begin
                    want = exp_q.pop_front();
                    check("event", 32'(got), 32'(want));
                end
            end
        end
    end

    // Stimulus
    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        low_cyc = 0;
        rst     = 1'b0;
        rxd     = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_data", 32'(data), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_eof", 32'(eof), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        rst = 1'b1;
        idle_bits(2);

        // Single payload byte
        push_ev(EV_VALID, 8'hA3);
        push_ev(EV_EOF, 8'h00);
        send_byte(8'h55, 1'b0);
        check("busy_in_frame1", 32'(busy), 32'h1);
        send_byte(8'hA3, 1'b0);
        check("busy_end_frame1", 32'(busy), 32'h1);
        idle_bits(4);
        check("busy_after_frame1", 32'(busy), 32'h0);

        // Runs of identical bits
        push_ev(EV_VALID, 8'h00);
        push_ev(EV_VALID, 8'hFF);
        push_ev(EV_VALID, 8'h81);
        push_ev(EV_EOF, 8'h00);
        send_byte(8'h55, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h81, 1'b0);
        idle_bits(4);
        check("data_held_81", 32'(data), 32'h81);

        // Bad preamble, then recovery with a good frame
        push_ev(EV_ERR, 8'h00);
        send_byte(8'h54, 1'b0);
        idle_bits(1);
        check("busy_errwait", 32'(busy), 32'h1);
        idle_bits(4);
        check("busy_after_errwait", 32'(busy), 32'h0);
        push_ev(EV_VALID, 8'h3C);
        push_ev(EV_EOF, 8'h00);
        send_byte(8'h55, 1'b0);
        send_byte(8'h3C, 1'b0);
        idle_bits(4);

        // Missing mid-bit in bit 4 of a payload byte, line held low
        push_ev(EV_ERR, 8'h00);
        send_byte(8'h55, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, BIT);
        rxd = 1'b0;
        low_cyc = cyc;
        repeat (3 * BIT) @(negedge clk);
        check("busy_line_low", 32'(busy), 32'h1);
        check("err_latency_ok",
              32'((err_cyc - low_cyc >= BIT - 4) && (err_cyc - low_cyc <= BIT + 12)), 32'h1);
        idle_bits(4);
        check("busy_after_violation", 32'(busy), 32'h0);

        // Short low glitch on an idle line
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        check("busy_after_glitch", 32'(busy), 32'h0);
        idle_bits(1);

        // Bit-period jitter
        push_ev(EV_VALID, 8'h5A);
        push_ev(EV_EOF, 8'h00);
        send_byte(8'h55, 1'b1);
        send_byte(8'h5A, 1'b1);
        idle_bits(4);
        check("data_jitter", 32'(data), 32'h5A);

        // Reset in the middle of bit 3 of a payload byte
        send_byte(8'h55, 1'b0);
        send_bit(1'b1, BIT);
        send_bit(1'b0, BIT);
        send_bit(1'b1, BIT);
        rxd = 1'b1;
        repeat (BIT / 4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_data", 32'(data), 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_valid", 32'(valid), 32'h0);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        idle_bits(2);
        push_ev(EV_VALID, 8'h11);
        push_ev(EV_EOF, 8'h00);
        send_byte(8'h55, 1'b0);
        send_byte(8'h11, 1'b0);
        idle_bits(4);
        check("data_after_reset", 32'(data), 32'h11);

        repeat (10) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
